link_port_arbiter: RTL and testbench

- Per-output-port arbiter in each torus node. It shares one outgoing link (xpos/xneg/ypos/yneg/zpos/zneg) among three requester classes: clockwise transit, counterclockwise transit and local injection.
- Grants are packet-atomic (wormhole lock head-to-tail), round-robin between packets, and gated by credits for the downstream input buffer.
- Produces the 8-bit ClockwiseUtil / CounterClockwiseUtil / InjectUtil statistics consumed by the network-level link summation counters.

---
 rtl/link_port_arbiter_pkg.sv | 22 ++
 rtl/link_util_counter.sv | 49 ++++
 rtl/link_port_arbiter.sv | 111 +++++++++++
 tb/tb_link_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_port_arbiter_pkg.sv
// rtl/link_port_arbiter_pkg.sv - shared constants, state encoding and helpers for the link port arbiter
package link_port_arbiter_pkg;

  localparam int FLIT_SIZE = 32;

  localparam int NUM_REQ = 3;
  localparam int REQ_CW  = 0;
  localparam int REQ_CCW = 1;
  localparam int REQ_INJ = 2;

  localparam int UTIL_W = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [UTIL_W-1:0] sat_add(input logic [UTIL_W-1:0] a, input logic inc);
    sat_add = (inc && (a != {UTIL_W{1'b1}})) ? a + 1'b1 : a;
  endfunction

endpackage

// File: rtl/link_util_counter.sv
// rtl/link_util_counter.sv - windowed per-class flit counters with saturating 8-bit results
module link_util_counter
  import link_port_arbiter_pkg::*;
#(
  parameter int WINDOW = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] inc,
  output logic [UTIL_W-1:0]  cw_util,
  output logic [UTIL_W-1:0]  ccw_util,
  output logic [UTIL_W-1:0]  inj_util
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [CNT_W-1:0]  win_cnt;
  logic              win_end;
  logic [UTIL_W-1:0] acc    [NUM_REQ];
  logic [UTIL_W-1:0] util_q [NUM_REQ];

  assign win_end = (win_cnt == CNT_W'(WINDOW - 1));

  // The final cycle's flit is folded into the published value, then accumulation restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        acc[i]    <= '0;
        util_q[i] <= '0;
      end
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win_end) begin
          util_q[i] <= sat_add(acc[i], inc[i]);
          acc[i]    <= '0;
        end else begin
          acc[i] <= sat_add(acc[i], inc[i]);
        end
      end
    end
  end

  assign cw_util  = util_q[REQ_CW];
  assign ccw_util = util_q[REQ_CCW];
  assign inj_util = util_q[REQ_INJ];

endmodule

// File: rtl/link_port_arbiter.sv
// rtl/link_port_arbiter.sv - wormhole round-robin credit-gated output link arbiter (option: BUBBLE_FLOW_EN)
module link_port_arbiter
  import link_port_arbiter_pkg::*;
#(
  parameter int FLIT_W  = FLIT_SIZE + 1,
  parameter int CREDITS = 4,
  parameter int WINDOW  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_tail,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_valid,
  input  logic                      credit_return,
  output logic [UTIL_W-1:0]         clockwise_util,
  output logic [UTIL_W-1:0]         counterclockwise_util,
  output logic [UTIL_W-1:0]         inject_util,
  output logic                      locked
);

  localparam logic [0:0] ST_IDLE   = ARB_IDLE;
  localparam logic [0:0] ST_LOCKED = ARB_LOCKED;

  logic [0:0]         state;
  logic [1:0]         owner;
  logic [1:0]         rr_ptr;
  logic [3:0]         credits;
  logic [3:0]         inj_need;
  logic [NUM_REQ-1:0] eligible;
  logic [1:0]         winner;
  logic               accept;
  logic               win_tail;
  logic [FLIT_W-1:0]  win_flit;

  // A fresh injected packet must leave one slot free so transit traffic can always drain.
`ifdef BUBBLE_FLOW_EN
  assign inj_need = 4'd2;
`else
  assign inj_need = 4'd1;
`endif

  always_comb begin
    eligible = '0;
    if (state == ST_LOCKED) begin
      if (credits != 4'd0) eligible[owner] = req_valid[owner];
    end else begin
      eligible[REQ_CW]  = req_valid[REQ_CW]  && (credits != 4'd0);
      eligible[REQ_CCW] = req_valid[REQ_CCW] && (credits != 4'd0);
      eligible[REQ_INJ] = req_valid[REQ_INJ] && (credits >= inj_need);
    end
  end

  // Descending scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    int idx;
    idx    = 0;
    winner = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (eligible[idx]) winner = 2'(idx);
    end
  end

  assign accept    = |eligible;
  assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
  assign win_tail  = req_tail[winner];
  assign win_flit  = req_flit[int'(winner)*FLIT_W +: FLIT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      credits   <= 4'(CREDITS);
      out_flit  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_flit <= win_flit;
        if (win_tail) begin
          state  <= ST_IDLE;
          rr_ptr <= (winner == 2'(REQ_INJ)) ? 2'd0 : winner + 2'd1;
        end else begin
          state <= ST_LOCKED;
          owner <= winner;
        end
      end
      if (accept && !credit_return) begin
        credits <= credits - 4'd1;
      end else if (!accept && credit_return && (credits != 4'(CREDITS))) begin
        credits <= credits + 4'd1;
      end
    end
  end

  assign locked = (state == ST_LOCKED);

  link_util_counter #(.WINDOW(WINDOW)) u_util (
    .clk      (clk),
    .rst      (rst),
    .inc      (req_ready),
    .cw_util  (clockwise_util),
    .ccw_util (counterclockwise_util),
    .inj_util (inject_util)
  );

endmodule

// File: tb/tb_link_port_arbiter.sv
// tb/tb_link_port_arbiter.sv - randomized and directed self-checking bench for link_port_arbiter
module tb_link_port_arbiter;
  import link_port_arbiter_pkg::*;

  localparam int FW   = FLIT_SIZE + 1;
  localparam int CR   = 4;
  localparam int WIN  = 16;
  localparam int SWIN = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [2:0]      req_valid = '0, req_tail = '0, req_ready;
  logic [3*FW-1:0] req_flit = '0;
  logic [FW-1:0]   out_flit;
  logic            out_valid, locked;
  logic            credit_return = 1'b0;
  logic [7:0]      cw_u, ccw_u, inj_u;

  logic            s_rst = 1'b1;
  logic [2:0]      s_valid = 3'b001, s_tail = 3'b001, s_ready;
  logic [3*FW-1:0] s_flit = '0;
  logic [FW-1:0]   s_out_flit;
  logic            s_out_valid, s_locked;
  logic            s_ret = 1'b0;
  logic [7:0]      s_cw, s_ccw, s_inj;

  link_port_arbiter #(.FLIT_W(FW), .CREDITS(CR), .WINDOW(WIN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tail(req_tail), .req_flit(req_flit),
    .req_ready(req_ready), .out_flit(out_flit), .out_valid(out_valid), .credit_return(credit_return),
    .clockwise_util(cw_u), .counterclockwise_util(ccw_u), .inject_util(inj_u), .locked(locked)
  );

  link_port_arbiter #(.FLIT_W(FW), .CREDITS(CR), .WINDOW(SWIN)) dut_sat (
    .clk(clk), .rst(s_rst), .req_valid(s_valid), .req_tail(s_tail), .req_flit(s_flit),
    .req_ready(s_ready), .out_flit(s_out_flit), .out_valid(s_out_valid), .credit_return(s_ret),
    .clockwise_util(s_cw), .counterclockwise_util(s_ccw), .inject_util(s_inj), .locked(s_locked)
  );

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;

  // reference model state
  int            m_credits = CR, m_owner = 0, m_rr = 0, m_pos = 0, m_win = -1;
  bit            m_locked = 0, m_out_valid = 0, last_acc = 0;
  logic [FW-1:0] m_out_flit = '0;
  int            m_acc [3] = '{0, 0, 0};
  int            m_util[3] = '{0, 0, 0};
  logic [2:0]    exp_ready = '0;

  // stimulus state
  int            mode = 0, ret_mode = 0, sat_cyc = 0;
  bit            ret_pulse = 0, rst_req = 0;
  bit            en[3];
  int            pkts_left[3], plen[3], rem[3];
  logic [FW-1:0] cur_flit[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [FW-1:0] rnd_flit();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[FW-1:0];
  endfunction

  function automatic int pick();
    int need;
    if (m_locked) return (req_valid[m_owner] && m_credits >= 1) ? m_owner : -1;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_rr + k) % 3;
      need = 1;
`ifdef BUBBLE_FLOW_EN
      if (c == 2) need = 2;
`endif
      if (req_valid[c] && m_credits >= need) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_credits = CR; m_locked = 0; m_owner = 0; m_rr = 0; m_pos = 0;
      m_out_valid = 0; m_out_flit = '0; last_acc = 0;
      for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_util[i] = 0; rem[i] = 0; end
    end else begin
      last_acc = (m_win >= 0);
      m_out_valid = last_acc;
      if (last_acc) begin
        m_out_flit = req_flit[m_win*FW +: FW];
        if (req_tail[m_win]) begin m_locked = 0; m_rr = (m_win + 1) % 3; end
        else begin m_locked = 1; m_owner = m_win; end
        rem[m_win]--;
        cur_flit[m_win] = rnd_flit();
        if (!credit_return) m_credits--;
        if (m_acc[m_win] < 255) m_acc[m_win]++;
      end else if (credit_return && m_credits < CR) begin
        m_credits++;
      end
      if (m_pos == WIN - 1) begin
        for (int i = 0; i < 3; i++) begin m_util[i] = m_acc[i]; m_acc[i] = 0; end
      end
      m_pos = (m_pos + 1) % WIN;
    end
  endtask

  task automatic gen_inputs();
    rst = rst_req;
    rst_req = 0;
    for (int i = 0; i < 3; i++) begin
      if (rem[i] == 0) begin
        if (mode == 1) begin
          if ($urandom_range(9, 0) < 5) rem[i] = $urandom_range(4, 1);
        end else if (en[i] && pkts_left[i] != 0) begin
          rem[i] = plen[i];
          if (pkts_left[i] > 0) pkts_left[i]--;
        end
      end
      req_valid[i] = (rem[i] != 0) && ((mode == 1) ? ($urandom_range(9, 0) < 8) : en[i]);
      req_tail[i]  = (rem[i] == 1);
      req_flit[i*FW +: FW] = cur_flit[i];
    end
    case (ret_mode)
      1:       credit_return = last_acc;
      2:       credit_return = ($urandom_range(9, 0) < 4);
      default: credit_return = 1'b0;
    endcase
    credit_return = credit_return | ret_pulse;
    ret_pulse = 0;
    if (mode == 1 && $urandom_range(999, 0) == 0) rst_req = 1;
  endtask

  task automatic cycle();
    bit s_acc_prev;
    s_acc_prev = (s_ready[0] === 1'b1);
    @(posedge clk);
    #1;
    model_step();
    gen_inputs();
    m_win = pick();
    exp_ready = (m_win >= 0) ? 3'(1 << m_win) : 3'b000;
    if (s_rst) begin
      s_rst = 1'b0;
      sat_cyc = 0;
    end else begin
      sat_cyc++;
      if (sat_cyc == SWIN - 1) check("sat_before_window", s_cw, 0);
      if (sat_cyc == SWIN) begin
        check("sat_cw_255", s_cw, 255);
        check("sat_ccw_0", s_ccw, 0);
        check("sat_inj_0", s_inj, 0);
      end
    end
    s_ret = s_acc_prev;
    #1;
  endtask

  task automatic run(input int n, input int cls, output int cnt);
    cnt = 0;
    repeat (n) begin
      cycle();
      if (cls < 0) begin
        if (|req_ready) cnt++;
      end else if (req_ready[cls]) begin
        cnt++;
      end
    end
  endtask

  task automatic reset_begin();
    mode = 0; ret_mode = 0; rst_req = 1;
    for (int i = 0; i < 3; i++) begin en[i] = 0; pkts_left[i] = 0; plen[i] = 1; end
    cycle();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, exp_ready);
      check("out_valid", out_valid, m_out_valid);
      check("out_flit",  out_flit,  m_out_flit);
      check("locked",    locked,    m_locked);
      check("cw_util",   cw_u,  m_util[0]);
      check("ccw_util",  ccw_u, m_util[1]);
      check("inj_util",  inj_u, m_util[2]);
    end
  end

  logic [2:0] a_exp[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  int cnt, tot;

  initial begin
    for (int i = 0; i < 3; i++) begin cur_flit[i] = rnd_flit(); rem[i] = 0; en[i] = 0; end

    // reset values
    reset_begin();
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_out_flit", out_flit, 0);
    check("rst_cw_util", cw_u, 0);
    check("rst_ccw_util", ccw_u, 0);
    check("rst_inj_util", inj_u, 0);
    chk_en = 1;

    // round-robin order among single-flit packets
    reset_begin();
    for (int i = 0; i < 3; i++) begin en[i] = 1; pkts_left[i] = -1; end
    ret_mode = 1;
    cycle();
    check("rr_grant0", req_ready, a_exp[0]);
    check("rr_no_out_yet", out_valid, 0);
    for (int j = 1; j < 6; j++) begin
      cycle();
      check("rr_grant", req_ready, a_exp[j]);
      if (j == 1) check("rr_out_valid_lat1", out_valid, 1);
    end

    // wormhole lock
    reset_begin();
    en[1] = 1; pkts_left[1] = 1; plen[1] = 3;
    pkts_left[0] = -1; pkts_left[2] = -1;
    ret_mode = 1;
    cycle();
    check("wh_head", req_ready, 3'b010);
    en[0] = 1; en[2] = 1;
    cycle();
    check("wh_body", req_ready, 3'b010);
    check("wh_locked1", locked, 1);
    cycle();
    check("wh_tail", req_ready, 3'b010);
    check("wh_locked2", locked, 1);
    cycle();
    check("wh_unlocked", locked, 0);
    check("wh_next_inj", req_ready, 3'b100);

    // credit exhaustion and return
    reset_begin();
    en[0] = 1; pkts_left[0] = 10;
    cycle();
    tot = req_ready[0];
    run(7, 0, cnt);
    check("cr_exhaust_4", tot + cnt, 4);
    check("cr_stalled", req_ready, 3'b000);
    ret_pulse = 1;
    run(3, 0, cnt);
    check("cr_one_more", cnt, 1);
    ret_pulse = 1;
    cycle();
    check("cr_pulse_no_acc", req_ready, 3'b000);
    ret_pulse = 1;
    cycle();
    check("cr_simul_acc", req_ready, 3'b001);
    run(3, 0, cnt);
    check("cr_simul_unchanged", cnt, 1);

    // credit saturation at CREDITS
    reset_begin();
    cycle();
    repeat (3) begin ret_pulse = 1; cycle(); end
    en[0] = 1; pkts_left[0] = 8;
    cycle();
    tot = req_ready[0];
    run(7, 0, cnt);
    check("cr_saturate_4", tot + cnt, 4);

    // bubble reservation for injection heads
    reset_begin();
    en[0] = 1; pkts_left[0] = 3;
    cycle();
    tot = req_ready[0];
    run(4, 0, cnt);
    check("bub_drain_3", tot + cnt, 3);
    en[2] = 1; pkts_left[2] = 1; plen[2] = 2;
    cycle();
`ifdef BUBBLE_FLOW_EN
    check("bub_inj_blocked", req_ready, 3'b000);
    pkts_left[0] = 1;
    cycle();
    check("bub_cw_granted", req_ready, 3'b001);
`else
    check("bub_inj_granted", req_ready, 3'b100);
`endif

    // utilization window
    reset_begin();
    en[0] = 1; pkts_left[0] = 10;
    en[2] = 1; pkts_left[2] = 3;
    ret_mode = 1;
    cycle();
    repeat (15) cycle();
    check("util_pre_cw", cw_u, 0);
    cycle();
    check("util_cw_10", cw_u, 10);
    check("util_ccw_0", ccw_u, 0);
    check("util_inj_3", inj_u, 3);

    // reset mid-packet
    reset_begin();
    en[0] = 1; pkts_left[0] = -1; plen[0] = 3;
    cycle();
    check("mid_head", req_ready, 3'b001);
    rst_req = 1;
    en[1] = 1; pkts_left[1] = -1;
    cycle();
    check("mid_locked", locked, 1);
    cycle();
    check("mid_rst_locked", locked, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_new_cw_first", req_ready, 3'b001);
    tot = |req_ready;
    run(7, -1, cnt);
    check("mid_credits_full", tot + cnt, 4);

    // randomized traffic against the model
    reset_begin();
    mode = 1; ret_mode = 2;
    cycle();
    repeat (2500) cycle();

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
